// File: rtl/risc_spm_run_ctrl.sv
// risc_spm_run_ctrl: Wishbone-controlled run controller for the RISC_SPM core.
// The core is held in reset while its 256x8 program memory is written through
// the loader port. Afterwards the controller sequences free-run, single-step,
// pause, abort and a cycle-limit timeout by gating the core's state advance.
module risc_spm_run_ctrl #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
    parameter logic [31:0] CTRL_ADDRESS   = BASE_ADDRESS,
    parameter logic [31:0] LOAD_ADDRESS   = BASE_ADDRESS + 32'd4,
    parameter logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd8,
    parameter logic [31:0] LIMIT_ADDRESS  = BASE_ADDRESS + 32'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    input  logic        core_halted,
    output logic        core_rst_n,
    output logic        core_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Register index order used by the address decoder.
    localparam int REG_CTRL   = 0;
    localparam int REG_LOAD   = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_LIMIT  = 3;

    localparam logic [3:0][31:0] REG_ADDR = {LIMIT_ADDRESS, STATUS_ADDRESS,
                                             LOAD_ADDRESS, CTRL_ADDRESS};

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic        core_rst_n_reg;
    logic        core_en_reg;
    logic [15:0] cycle_count_reg;
    logic [15:0] limit_reg;
    logic        halted_reg;
    logic        timeout_reg;
    logic        load_err_reg;
    logic        mem_we_reg;
    logic [7:0]  mem_addr_reg;
    logic [7:0]  mem_wdata_reg;
    logic        ack_reg;
    logic [31:0] rdata_reg;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        wb_access;
    logic [3:0]  reg_hit;
    logic        ctrl_wr;
    logic        load_wr;
    logic        limit_wr;
    logic        cmd_abort;
    logic        cmd_stop;
    logic        cmd_step;
    logic        cmd_start;
    logic [31:0] status_word;
    logic [31:0] read_word;
    logic        unused_wb_data;

    // The bus never stalls, so every strobe inside a cycle is an access.
    assign o_wb_stall = 1'b0;
    assign wb_access  = i_wb_cyc & i_wb_stb & ~o_wb_stall;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign reg_hit[gi] = (i_wb_addr == REG_ADDR[gi]);
        end
    endgenerate

    assign ctrl_wr  = wb_access & i_wb_we & reg_hit[REG_CTRL];
    assign load_wr  = wb_access & i_wb_we & reg_hit[REG_LOAD];
    assign limit_wr = wb_access & i_wb_we & reg_hit[REG_LIMIT];

    // Only the highest-priority set bit counts as the command; a lower bit
    // never takes effect when a higher one is present, even if the higher
    // command is a no-op in the current state.
    assign cmd_abort = ctrl_wr & i_wb_data[3];
    assign cmd_stop  = ctrl_wr & i_wb_data[2] & ~i_wb_data[3];
    assign cmd_step  = ctrl_wr & i_wb_data[1] & ~i_wb_data[2] & ~i_wb_data[3];
    assign cmd_start = ctrl_wr & i_wb_data[0] & ~i_wb_data[1] & ~i_wb_data[2]
                     & ~i_wb_data[3];

    // Upper write-data bits carry no meaning in any register.
    assign unused_wb_data = &{1'b0, i_wb_data[31:16]};

    assign status_word = {9'd0, state_reg, 1'b0, load_err_reg, timeout_reg,
                          halted_reg, cycle_count_reg};

    // Read mux: only STATUS and LIMIT return data; everything else reads 0.
    always_comb begin
        read_word = 32'd0;
        if (reg_hit[REG_STATUS]) begin
            read_word = status_word;
        end else if (reg_hit[REG_LIMIT]) begin
            read_word = {16'd0, limit_reg};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [16:0] count_plus1;
    logic        limit_hit;
    logic        set_halted;
    logic        set_timeout;
    logic        leave_idle;

    // Extra bit keeps a saturated counter from wrapping onto a limit of 0.
    assign count_plus1 = {1'b0, cycle_count_reg} + 17'd1;
    assign limit_hit   = (limit_reg != 16'd0) && (count_plus1 == {1'b0, limit_reg});

    // Sequencing rules: commands beat halt/limit in RUN, but a halt seen in
    // that same cycle is still recorded.
    always_comb begin
        state_next  = state_reg;
        set_halted  = 1'b0;
        set_timeout = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_step) begin
                    state_next = ST_STEP;
                end else if (cmd_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                set_halted = core_halted;
                if (cmd_abort) begin
                    state_next = ST_IDLE;
                end else if (cmd_stop) begin
                    state_next = ST_PAUSE;
                end else if (core_halted) begin
                    state_next = ST_DONE;
                end else if (limit_hit) begin
                    state_next  = ST_PAUSE;
                    set_timeout = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (cmd_abort) begin
                    state_next = ST_IDLE;
                end else if (cmd_step) begin
                    state_next = ST_STEP;
                end else if (cmd_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_STEP: begin
                set_halted = core_halted;
                if (cmd_abort) begin
                    state_next = ST_IDLE;
                end else if (core_halted) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (cmd_abort) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign leave_idle = (state_reg == ST_IDLE) && (state_next != ST_IDLE);

    // FSM state plus the core reset/enable, registered from the next state so
    // they always match the state the controller is in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            core_rst_n_reg <= 1'b0;
            core_en_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            core_rst_n_reg <= (state_next != ST_IDLE);
            core_en_reg    <= (state_next == ST_RUN) || (state_next == ST_STEP);
        end
    end

    // Cycle counter and sticky flags; all cleared only when leaving IDLE so an
    // aborted run stays inspectable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_reg <= 16'd0;
            halted_reg      <= 1'b0;
            timeout_reg     <= 1'b0;
            load_err_reg    <= 1'b0;
        end else if (leave_idle) begin
            cycle_count_reg <= 16'd0;
            halted_reg      <= 1'b0;
            timeout_reg     <= 1'b0;
            load_err_reg    <= 1'b0;
        end else begin
            if (core_en_reg && (cycle_count_reg != 16'hFFFF)) begin
                cycle_count_reg <= cycle_count_reg + 16'd1;
            end
            if (set_halted) begin
                halted_reg <= 1'b1;
            end
            if (set_timeout) begin
                timeout_reg <= 1'b1;
            end
            if (load_wr && (state_reg != ST_IDLE)) begin
                load_err_reg <= 1'b1;
            end
        end
    end

    // Cycle limit register; a new value is compared from the next cycle on.
    always_ff @(posedge clk) begin
        if (reset) begin
            limit_reg <= 16'd0;
        end else if (limit_wr) begin
            limit_reg <= i_wb_data[15:0];
        end
    end

    // Program loader: a LOAD in IDLE produces one write strobe into core memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 8'd0;
            mem_wdata_reg <= 8'd0;
        end else begin
            mem_we_reg <= load_wr && (state_reg == ST_IDLE);
            if (load_wr && (state_reg == ST_IDLE)) begin
                mem_addr_reg  <= i_wb_data[15:8];
                mem_wdata_reg <= i_wb_data[7:0];
            end
        end
    end

    // Bus response: ack mapped registers one cycle after the access and
    // register the read data on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            ack_reg <= wb_access && (reg_hit != 4'd0);
            if (wb_access && (reg_hit != 4'd0)) begin
                rdata_reg <= read_word;
            end
        end
    end

    assign o_wb_ack   = ack_reg;
    assign o_wb_data  = rdata_reg;
    assign core_rst_n = core_rst_n_reg;
    assign core_en    = core_en_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule
